// File: rtl/ex_flag_commit_pkg.sv
// Shared constants and helpers for the EX/MEM flag-commit stage.
// Opcode field layout, condition encodings and default widths live here.
package ex_flag_commit_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 3;
  localparam int CNT_W_DEF      = 16;

  // ALU operation field, opcode[5:4]
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;

  localparam int CWE_BIT = 3;
  localparam int ZWE_BIT = 2;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_RSVD   = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic       cwe;
    logic       zwe;
  } alu_ctl_t;

  function automatic alu_ctl_t decode_ctl(input logic [5:0] opcode);
    alu_ctl_t ctl;
    ctl.op  = opcode[5:4];
    ctl.cwe = opcode[CWE_BIT];
    ctl.zwe = opcode[ZWE_BIT];
    return ctl;
  endfunction

  // Reserved condition behaves as unconditional.
  function automatic logic cond_eval(input logic [1:0] cond,
                                     input logic       c_flag,
                                     input logic       z_flag);
    logic pass;
    unique case (cond)
      COND_ALWAYS: pass = 1'b1;
      COND_C:      pass = c_flag;
      COND_Z:      pass = z_flag;
      default:     pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/ex_flag_commit_flag_cond_unit.sv
// Architectural C/Z flag registers plus condition resolution.
// Flags move only on a committing edge for an instruction whose condition passed.
module flag_cond_unit
  import ex_flag_commit_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       commit_i,
  input  logic       valid_i,
  input  alu_ctl_t   ctl_i,
  input  logic [1:0] cond_i,
  input  logic       alu_c_i,
  input  logic       alu_z_i,
  output logic       cond_pass_o,
  output logic       fire_o,
  output logic       c_flag_o,
  output logic       z_flag_o
);

  logic c_q, c_d;
  logic z_q, z_d;
  logic cond_pass;
  logic fire;

  assign cond_pass = cond_eval(cond_i, c_q, z_q);
  assign fire      = valid_i & cond_pass;

  always_comb begin
    c_d = c_q;
    z_d = z_q;
    if (commit_i && fire) begin
      unique case (ctl_i.op)
        OP_ADD, OP_NAND: begin
          if (ctl_i.cwe) c_d = alu_c_i;
          if (ctl_i.zwe) z_d = alu_z_i;
        end
        // Compare always writes Z and never touches C.
        OP_CMP:  z_d = alu_z_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      c_q <= c_d;
      z_q <= z_d;
    end
  end

  assign cond_pass_o = cond_pass;
  assign fire_o      = fire;
  assign c_flag_o    = c_q;
  assign z_flag_o    = z_q;

endmodule

// File: rtl/ex_flag_commit.sv
// EX/MEM boundary register with conditional-execution squash and flag commit.
// Edge priority is reset, then flush, then stall, then normal update.
module ex_flag_commit
  import ex_flag_commit_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  In_clk,
  input  logic                  In_reset,
  input  logic                  In_valid,
  input  logic                  In_stall,
  input  logic                  In_flush,
  input  logic [5:0]            In_ALU_opcode,
  input  logic [1:0]            In_cond,
  input  logic [DATA_W-1:0]     In_ALU_result,
  input  logic                  In_ALU_CFlag,
  input  logic                  In_ALU_ZFlag,
  input  logic [REG_ADDR_W-1:0] In_rd_addr,
  input  logic                  In_rd_wen,
  input  logic [DATA_W-1:0]     In_pc,
  output logic                  Out_valid,
  output logic [DATA_W-1:0]     Out_result,
  output logic [REG_ADDR_W-1:0] Out_rd_addr,
  output logic                  Out_rd_wen,
  output logic [DATA_W-1:0]     Out_pc,
  output logic                  Out_squashed,
  output logic                  Out_CFlag,
  output logic                  Out_ZFlag,
  output logic [CNT_W-1:0]      Out_squash_count
);

  logic                  commit;
  logic                  cond_pass;
  logic                  fire;
  alu_ctl_t              ctl;

  logic                  valid_q,  valid_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic [REG_ADDR_W-1:0] rd_q,     rd_d;
  logic                  wen_q,    wen_d;
  logic [DATA_W-1:0]     pc_q,     pc_d;
  logic                  sq_q,     sq_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;

  assign commit = ~In_flush & ~In_stall;
  assign ctl    = decode_ctl(In_ALU_opcode);

  flag_cond_unit u_flag_cond (
    .clk_i       (In_clk),
    .rst_i       (In_reset),
    .commit_i    (commit),
    .valid_i     (In_valid),
    .ctl_i       (ctl),
    .cond_i      (In_cond),
    .alu_c_i     (In_ALU_CFlag),
    .alu_z_i     (In_ALU_ZFlag),
    .cond_pass_o (cond_pass),
    .fire_o      (fire),
    .c_flag_o    (Out_CFlag),
    .z_flag_o    (Out_ZFlag)
  );

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    wen_d    = wen_q;
    pc_d     = pc_q;
    sq_d     = sq_q;
    cnt_d    = cnt_q;
    if (In_flush) begin
      // Kill only the control bits; data fields keep their last value.
      valid_d = 1'b0;
      wen_d   = 1'b0;
      sq_d    = 1'b0;
    end else if (!In_stall) begin
      valid_d  = In_valid;
      result_d = In_ALU_result;
      rd_d     = In_rd_addr;
      pc_d     = In_pc;
      wen_d    = In_rd_wen & fire;
      sq_d     = In_valid & ~cond_pass;
      if (In_valid && !cond_pass && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge In_clk or posedge In_reset) begin
    if (In_reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      pc_q     <= '0;
      sq_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
      pc_q     <= pc_d;
      sq_q     <= sq_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Out_valid        = valid_q;
  assign Out_result       = result_q;
  assign Out_rd_addr      = rd_q;
  assign Out_rd_wen       = wen_q;
  assign Out_pc           = pc_q;
  assign Out_squashed     = sq_q;
  assign Out_squash_count = cnt_q;

endmodule

// File: tb/tb_ex_flag_commit.sv
// Self-checking bench for ex_flag_commit: directed scenarios then random traffic
// compared against a behavioural model of the stage.
module tb_ex_flag_commit;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          In_clk = 1'b0;
  logic          In_reset;
  logic          In_valid, In_stall, In_flush;
  logic [5:0]    In_ALU_opcode;
  logic [1:0]    In_cond;
  logic [DW-1:0] In_ALU_result;
  logic          In_ALU_CFlag, In_ALU_ZFlag;
  logic [AW-1:0] In_rd_addr;
  logic          In_rd_wen;
  logic [DW-1:0] In_pc;
  logic          Out_valid;
  logic [DW-1:0] Out_result;
  logic [AW-1:0] Out_rd_addr;
  logic          Out_rd_wen;
  logic [DW-1:0] Out_pc;
  logic          Out_squashed;
  logic          Out_CFlag, Out_ZFlag;
  logic [CW-1:0] Out_squash_count;

  int checks = 0;
  int errors = 0;

  // reference state
  int m_valid, m_res, m_rd, m_wen, m_pc, m_sq, m_c, m_z, m_cnt;

  ex_flag_commit #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .In_clk(In_clk), .In_reset(In_reset), .In_valid(In_valid),
    .In_stall(In_stall), .In_flush(In_flush), .In_ALU_opcode(In_ALU_opcode),
    .In_cond(In_cond), .In_ALU_result(In_ALU_result),
    .In_ALU_CFlag(In_ALU_CFlag), .In_ALU_ZFlag(In_ALU_ZFlag),
    .In_rd_addr(In_rd_addr), .In_rd_wen(In_rd_wen), .In_pc(In_pc),
    .Out_valid(Out_valid), .Out_result(Out_result), .Out_rd_addr(Out_rd_addr),
    .Out_rd_wen(Out_rd_wen), .Out_pc(Out_pc), .Out_squashed(Out_squashed),
    .Out_CFlag(Out_CFlag), .Out_ZFlag(Out_ZFlag),
    .Out_squash_count(Out_squash_count)
  );

  always #5 In_clk = ~In_clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, int'(Out_valid), m_valid);
    chk({tag, ".result"}, int'(Out_result), m_res);
    chk({tag, ".rd"}, int'(Out_rd_addr), m_rd);
    chk({tag, ".wen"}, int'(Out_rd_wen), m_wen);
    chk({tag, ".pc"}, int'(Out_pc), m_pc);
    chk({tag, ".sq"}, int'(Out_squashed), m_sq);
    chk({tag, ".C"}, int'(Out_CFlag), m_c);
    chk({tag, ".Z"}, int'(Out_ZFlag), m_z);
    chk({tag, ".cnt"}, int'(Out_squash_count), m_cnt);
  endtask

  task automatic model_reset();
    m_valid = 0; m_res = 0; m_rd = 0; m_wen = 0; m_pc = 0;
    m_sq = 0; m_c = 0; m_z = 0; m_cnt = 0;
  endtask

  // Apply the stage rules to the inputs currently on the pins.
  task automatic model_edge();
    int op, pass;
    op = int'(In_ALU_opcode) / 16;
    pass = (In_cond == 2'b00 || In_cond == 2'b11 ||
            (In_cond == 2'b10 && m_c == 1) || (In_cond == 2'b01 && m_z == 1)) ? 1 : 0;
    if (In_flush) begin
      m_valid = 0; m_wen = 0; m_sq = 0;
    end else if (!In_stall) begin
      m_valid = int'(In_valid);
      m_res = int'(In_ALU_result);
      m_rd = int'(In_rd_addr);
      m_pc = int'(In_pc);
      m_wen = (In_rd_wen && In_valid && pass == 1) ? 1 : 0;
      m_sq = (In_valid && pass == 0) ? 1 : 0;
      if (In_valid && pass == 1) begin
        if (op == 1 || op == 2) begin
          if (In_ALU_opcode[3]) m_c = int'(In_ALU_CFlag);
          if (In_ALU_opcode[2]) m_z = int'(In_ALU_ZFlag);
        end else if (op == 3) begin
          m_z = int'(In_ALU_ZFlag);
        end
      end
      if (In_valid && pass == 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic fl,
                       input logic [5:0] opc, input logic [1:0] cnd,
                       input logic [DW-1:0] res, input logic c, input logic z,
                       input logic [AW-1:0] rd, input logic wen,
                       input logic [DW-1:0] pc);
    In_valid = v; In_stall = st; In_flush = fl; In_ALU_opcode = opc;
    In_cond = cnd; In_ALU_result = res; In_ALU_CFlag = c; In_ALU_ZFlag = z;
    In_rd_addr = rd; In_rd_wen = wen; In_pc = pc;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge In_clk);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges and confirm outputs clear before the next edge.
  task automatic async_reset(input string tag);
    #3;
    In_reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".pre_edge"});
    @(posedge In_clk);
    #1;
    In_reset = 1'b0;
    check_all({tag, ".post"});
  endtask

  task automatic drive_random();
    drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 9) == 0), 6'($urandom), 2'($urandom),
          DW'($urandom), 1'($urandom), 1'($urandom), AW'($urandom),
          1'($urandom), DW'($urandom));
  endtask

  initial begin
    In_reset = 1'b1;
    drive(0, 0, 0, 6'h0, 2'b00, '0, 0, 0, '0, 0, '0);
    model_reset();
    repeat (2) @(posedge In_clk);
    #1;
    check_all("reset");
    In_reset = 1'b0;

    // add with carry/zero write
    drive(1, 0, 0, 6'b011100, 2'b00, 16'h0000, 1, 1, 3'd3, 1, 16'h0010);
    step("add_cw");
    chk("add_cw.result_lit", int'(Out_result), 0);
    chk("add_cw.wen_lit", int'(Out_rd_wen), 1);
    chk("add_cw.C_lit", int'(Out_CFlag), 1);
    chk("add_cw.Z_lit", int'(Out_ZFlag), 1);

    // clear both flags, then ADC fails
    drive(1, 0, 0, 6'b011100, 2'b00, 16'h1234, 0, 0, 3'd1, 1, 16'h0012);
    step("clr_flags");
    drive(1, 0, 0, 6'b010000, 2'b10, 16'h5555, 1, 1, 3'd2, 1, 16'h0014);
    step("adc_fail");
    chk("adc_fail.wen_lit", int'(Out_rd_wen), 0);
    chk("adc_fail.sq_lit", int'(Out_squashed), 1);
    chk("adc_fail.cnt_lit", int'(Out_squash_count), 1);
    chk("adc_fail.C_lit", int'(Out_CFlag), 0);

    // set C then ADC back-to-back
    drive(1, 0, 0, 6'b011000, 2'b00, 16'h0001, 1, 0, 3'd4, 1, 16'h0016);
    step("set_c");
    drive(1, 0, 0, 6'b010000, 2'b10, 16'h0abc, 0, 0, 3'd5, 1, 16'h0018);
    step("adc_pass");
    chk("adc_pass.wen_lit", int'(Out_rd_wen), 1);
    chk("adc_pass.sq_lit", int'(Out_squashed), 0);

    // compare writes Z only
    drive(1, 0, 0, 6'b110000, 2'b00, 16'h0000, 0, 1, 3'd6, 1, 16'h001a);
    step("cmp");
    chk("cmp.Z_lit", int'(Out_ZFlag), 1);
    chk("cmp.C_lit", int'(Out_CFlag), 1);
    chk("cmp.wen_lit", int'(Out_rd_wen), 1);

    // three stalled cycles with changing inputs
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 6'b011100, 2'b00, DW'($urandom), 0, 0, 3'd7, 1, DW'($urandom));
      step("stall");
      chk("stall.pc_lit", int'(Out_pc), 16'h001a);
    end
    drive(1, 1, 1, 6'b011100, 2'b00, 16'hffff, 0, 0, 3'd7, 1, 16'h0020);
    step("stall_flush");
    chk("stall_flush.valid_lit", int'(Out_valid), 0);
    chk("stall_flush.C_lit", int'(Out_CFlag), 1);

    // reset while stalled, then saturate the counter
    drive(1, 1, 0, 6'b011100, 2'b00, 16'h7777, 1, 1, 3'd1, 1, 16'h0030);
    async_reset("rst_stall");
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 6'b011100, 2'b10, DW'(i), 1, 1, 3'd2, 1, DW'(i));
      step("sat");
    end
    chk("sat.cnt_lit", int'(Out_squash_count), CNT_MAX);

    // random traffic with occasional async reset
    async_reset("rnd_start");
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
      else step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_flag_commit.md
Name: ex_flag_commit

Overview:
- Pipeline stage directly downstream of the execute ALU: registers the ALU result, destination and PC into the EX/MEM boundary.
- Owns the architectural carry (C) and zero (Z) flag registers.
- Resolves conditional execution (ADC/ADZ/NDC/NDZ style): an instruction whose condition fails is squashed, with no register write and no flag update.
- Handles pipeline stall and flush, and keeps a saturating count of squashed instructions.

Parameters:
- DATA_W, 16, width of ALU result and PC.
- REG_ADDR_W, 3, register-file address width.
- CNT_W, 16, width of squash counter.

Ports:
- In_clk  input  1  clock, rising-edge.
- In_reset  input  1  asynchronous, active-high reset.
- In_valid  input  1  execute stage holds a real instruction this cycle.
- In_stall  input  1  hold this stage (downstream not ready).
- In_flush  input  1  kill the instruction entering this stage (branch redirect).
- In_ALU_opcode  input  6  same encoding the ALU consumes: [5:4] op (00 nop, 01 add, 10 nand, 11 compare), [3] carry-write enable, [2] zero-write enable.
- In_cond  input  2  00 always, 10 execute if C=1, 01 execute if Z=1, 11 reserved (treated as always).
- In_ALU_result  input  DATA_W  ALU result.
- In_ALU_CFlag  input  1  ALU carry out.
- In_ALU_ZFlag  input  1  ALU zero out.
- In_rd_addr  input  REG_ADDR_W  destination register.
- In_rd_wen  input  1  instruction writes a register.
- In_pc  input  DATA_W  instruction PC.
- Out_valid  output  1  registered valid.
- Out_result  output  DATA_W  registered result.
- Out_rd_addr  output  REG_ADDR_W  registered destination.
- Out_rd_wen  output  1  registered write enable, qualified by the condition.
- Out_pc  output  DATA_W  registered PC.
- Out_squashed  output  1  registered; stage holds a valid instruction whose condition failed.
- Out_CFlag  output  1  architectural C.
- Out_ZFlag  output  1  architectural Z.
- Out_squash_count  output  CNT_W  saturating count of squashed instructions.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-stall):
  - Out_valid, Out_rd_wen, Out_squashed, Out_CFlag, Out_ZFlag = 0.
  - Out_result, Out_pc, Out_rd_addr = 0.
  - Out_squash_count = 0.
- Condition evaluation is combinational against the current Out_CFlag/Out_ZFlag:
  - cond_pass = (In_cond==00) | (In_cond==11) | (In_cond==10 & Out_CFlag) | (In_cond==01 & Out_ZFlag).
  - Back-to-back dependency: a flag written by instruction N is visible to instruction N+1 with no bubble, because it is registered at the edge between them.
  - fire = In_valid & cond_pass.
- Priority at each rising edge: reset > flush > stall > normal.
- Flush:
  - Out_valid, Out_rd_wen, Out_squashed <= 0.
  - Data fields and flags are unchanged.
  - Counter is unchanged.
  - Flush wins over a simultaneous stall.
- Stall (no flush):
  - All outputs hold, flags included.
  - The input instruction is not consumed; the upstream stage must hold it.
- Normal register update:
  - Out_valid <= In_valid.
  - Out_result, Out_pc, Out_rd_addr <= inputs.
  - Out_rd_wen <= In_rd_wen & fire.
  - Out_squashed <= In_valid & ~cond_pass.
- Normal flag update (only when fire):
  - op 01 or 10: C <= In_ALU_CFlag if [3]; Z <= In_ALU_ZFlag if [2].
  - op 11: Z <= In_ALU_ZFlag; C unchanged.
  - op 00: no flag change.
- Squashed or invalid instruction: flags never change.
- Counter: increments by 1 on each normal-update edge where In_valid & ~cond_pass; it saturates at all-ones and never wraps.
- Latency: one cycle, input to Out_* register.
- Flag outputs are architectural state, not per-instruction.

Decomposition:
- Shared package holds:
  - ALU op constants: OP_NOP=2'b00, OP_ADD=2'b01, OP_NAND=2'b10, OP_CMP=2'b11.
  - Opcode bit indices: CWE_BIT=3, ZWE_BIT=2.
  - Condition constants: COND_ALWAYS=00, COND_C=10, COND_Z=01.
  - DATA_W/REG_ADDR_W defaults.
- One sub-module is natural: flag_cond_unit, which holds the C/Z registers and produces cond_pass and next-flag values.
- The top level holds the pipeline register and the squash counter.

Test Plan:
- Reset mid-stream: In_reset asserted asynchronously between edges -> all outputs 0 immediately, before the next edge.
- Add with carry write: opcode 6'b011100, result 0x0000, C=1, Z=1, cond 00 -> next cycle Out_result=0x0000, Out_rd_wen=1, Out_CFlag=1, Out_ZFlag=1.
- Conditional fail then pass: flags C=0 Z=0, then ADC (cond 10, rd_wen 1) -> Out_rd_wen=0, Out_squashed=1, flags unchanged, count=1. Then an add sets C=1 and is followed immediately by ADC -> Out_rd_wen=1, Out_squashed=0.
- Compare: opcode 6'b110000 with In_ALU_ZFlag=1 and C=1 beforehand -> Z=1, C stays 1, Out_rd_wen follows In_rd_wen.
- Stall and flush together: hold stall 3 cycles -> outputs and flags frozen. Then assert stall and flush in the same cycle with a valid add -> Out_valid=0, flags unchanged.
- Counter saturation: CNT_W=4 with 17 consecutive squashed instructions -> Out_squash_count=4'hF, with no wrap to 0.
